// File: rtl/pq_client_pkg.sv
// Shared types for the priority-queue client sequencer: command opcodes,
// FSM states and the per-operation recovery-gap lookup.
package pq_client_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_REP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  function automatic int unsigned max3_u(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // OP_NONE never reaches ISSUE; it maps to the minimum legal gap.
  function automatic int unsigned gap_sel(input op_t         op,
                                          input int unsigned enq_gap,
                                          input int unsigned deq_gap,
                                          input int unsigned rep_gap);
    case (op)
      OP_ENQ:  return enq_gap;
      OP_DEQ:  return deq_gap;
      OP_REP:  return rep_gap;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/pq_client_sequencer.sv
// Client-side initiator for the hybrid-tree priority queue: one strobe per
// legal command, then an op-dependent idle gap; single-entry response slot.
module pq_client_sequencer
  import pq_client_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ENQ_GAP    = 4,
  parameter int unsigned DEQ_GAP    = 24,
  parameter int unsigned REP_GAP    = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_top
);

  localparam int unsigned GAP_MAX = max3_u(ENQ_GAP, DEQ_GAP, REP_GAP);
  localparam int unsigned CNT_W   = $clog2(GAP_MAX + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  op_t                   r_op;
  op_t                   w_op;
  logic                  w_legal;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  r_pq_wrt;
  logic                  r_pq_read;
  logic [DATA_WIDTH-1:0] r_pq_data;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  assign w_op        = op_t'(i_cmd_op);
  assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid && !RST;
  assign w_accept    = i_cmd_valid && w_cmd_ready;

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_ENQ:  w_legal = !i_pq_full;
      OP_DEQ:  w_legal = !i_pq_empty;
      OP_REP:  w_legal = !i_pq_empty;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_cnt_nxt   = CNT_W'(gap_sel(r_op, ENQ_GAP, DEQ_GAP, REP_GAP) - 1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Strobes are registered at the accept edge so they are high exactly
  // while the FSM sits in ISSUE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op      <= OP_NONE;
      r_pq_wrt  <= 1'b0;
      r_pq_read <= 1'b0;
      r_pq_data <= '0;
    end else begin
      r_pq_wrt  <= 1'b0;
      r_pq_read <= 1'b0;
      if (w_accept && w_legal) begin
        r_op      <= w_op;
        r_pq_data <= i_cmd_data;
        r_pq_wrt  <= (w_op == OP_ENQ) || (w_op == OP_REP);
        r_pq_read <= (w_op == OP_DEQ) || (w_op == OP_REP);
      end
    end
  end

  // Ready already excludes a held response, so drain and accept never coincide.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if (r_rsp_valid && i_rsp_ready) r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= !w_legal;
        r_rsp_data  <= (w_legal && (w_op != OP_ENQ)) ? i_pq_top : '0;
      end
    end
  end

  assign o_cmd_ready = w_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_data  = r_rsp_data;
  assign o_pq_wrt    = r_pq_wrt;
  assign o_pq_read   = r_pq_read;
  assign o_pq_data   = r_pq_data;

endmodule

// File: tb/tb_pq_client_sequencer.sv
// Randomized bench for pq_client_sequencer against a behavioural priority-queue
// model and per-command timing expectations.
module tb_pq_client_sequencer;

  localparam int DW      = 16;
  localparam int ENQ_GAP = 4;
  localparam int DEQ_GAP = 24;
  localparam int REP_GAP = 4;
  localparam int CAP     = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_op;
  logic [DW-1:0] i_cmd_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_pq_wrt;
  logic          o_pq_read;
  logic [DW-1:0] o_pq_data;
  logic          i_pq_full;
  logic          i_pq_empty;
  logic [DW-1:0] i_pq_top;

  int            n_checks = 0;
  int            n_fail   = 0;
  int unsigned   q[$];
  logic [DW-1:0] last_wdata;

  pq_client_sequencer #(
    .DATA_WIDTH(DW), .ENQ_GAP(ENQ_GAP), .DEQ_GAP(DEQ_GAP), .REP_GAP(REP_GAP)
  ) dut (
    .CLK(CLK), .RST(RST),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
    .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_top(i_pq_top)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned q_max();
    int unsigned m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic q_pop();
    int idx = 0;
    foreach (q[i]) if (q[i] > q[idx]) idx = i;
    if (q.size() > 0) q.delete(idx);
  endtask

  task automatic pins();
    i_pq_full  = (q.size() >= CAP);
    i_pq_empty = (q.size() == 0);
    i_pq_top   = DW'(q_max());
  endtask

  // Issue one command from a negedge and follow it until ready returns.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input int hold);
    bit            legal;
    bit            exp_w;
    bit            exp_r;
    logic [DW-1:0] exp_rsp;
    int            gap;
    int            c;
    int            strobes;
    int            exp_c;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = d;
    c = 0;
    while (!o_cmd_ready && c < 200) begin
      @(negedge CLK);
      c++;
    end
    if (!o_cmd_ready) begin
      check("accept_timeout", 32'(o_cmd_ready), 32'd1);
      i_cmd_valid = 1'b0;
      return;
    end
    legal   = !((op == 2'b00) || (op == 2'b01 && q.size() >= CAP) ||
                (op != 2'b01 && q.size() == 0));
    exp_w   = legal && (op == 2'b01 || op == 2'b11);
    exp_r   = legal && (op == 2'b10 || op == 2'b11);
    exp_rsp = (legal && op != 2'b01) ? DW'(q_max()) : '0;
    gap     = (op == 2'b01) ? ENQ_GAP : (op == 2'b10) ? DEQ_GAP : REP_GAP;

    @(negedge CLK);
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'($urandom);
    i_cmd_data  = DW'($urandom);
    check("strobe_wrt", 32'(o_pq_wrt), 32'(exp_w));
    check("strobe_read", 32'(o_pq_read), 32'(exp_r));
    if (exp_w) check("pq_data", 32'(o_pq_data), 32'(d));
    check("rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("rsp_err", 32'(o_rsp_err), 32'(!legal));
    check("rsp_data", 32'(o_rsp_data), 32'(exp_rsp));
    check("ready_busy", 32'(o_cmd_ready), 32'd0);
    if (legal) begin
      last_wdata = d;
      if (op == 2'b01) q.push_back(32'(d));
      else if (op == 2'b10) q_pop();
      else begin
        q_pop();
        q.push_back(32'(d));
      end
      pins();
    end

    i_rsp_ready = (hold == 0);
    c = 1;
    strobes = 0;
    while (c < 400) begin
      @(negedge CLK);
      c++;
      strobes += int'(o_pq_wrt) + int'(o_pq_read);
      if (c <= hold + 1) begin
        check("rsp_hold_valid", 32'(o_rsp_valid), 32'd1);
        check("rsp_hold_data", 32'(o_rsp_data), 32'(exp_rsp));
      end
      if (o_cmd_ready) break;
      i_rsp_ready = (c >= hold + 1);
    end
    exp_c = hold + 2;
    if (legal && gap + 2 > exp_c) exp_c = gap + 2;
    check("ready_cycle", 32'(c), 32'(exp_c));
    check("gap_strobes", 32'(strobes), 32'd0);
    check("rsp_drained", 32'(o_rsp_valid), 32'd0);
    check("pq_data_hold", 32'(o_pq_data), 32'(last_wdata));
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [DW-1:0] exp_top;
    RST         = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b01;
    i_cmd_data  = 16'h5555;
    i_rsp_ready = 1'b0;
    last_wdata  = '0;
    pins();
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_wrt", 32'(o_pq_wrt), 32'd0);
    check("rst_read", 32'(o_pq_read), 32'd0);
    check("rst_pq_data", 32'(o_pq_data), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
    i_cmd_valid = 1'b0;
    RST         = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 32'(o_cmd_ready), 32'd1);

    send(2'b10, 16'h0000, 2);
    send(2'b01, 16'h0100, 0);
    send(2'b01, 16'h0400, 0);
    send(2'b11, 16'h0010, 0);
    repeat (20) send(2'b11, DW'($urandom), 0);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      send(2'b10, DW'($urandom), $urandom_range(0, 2));
      guard++;
    end
    send(2'b01, 16'h0333, 0);
    send(2'b10, 16'h0000, 0);

    guard = 0;
    while (q.size() < CAP && guard < 20) begin
      send(2'b01, DW'($urandom), 0);
      guard++;
    end
    send(2'b01, 16'hBEEF, 10);
    send(2'b11, DW'($urandom), 1);

    repeat (30) send(2'($urandom_range(0, 3)), DW'($urandom), $urandom_range(0, 3));

    if (q.size() == 0) send(2'b01, 16'h0777, 0);
    exp_top     = DW'(q_max());
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'b10;
    i_cmd_data  = 16'h0000;
    guard = 0;
    while (!o_cmd_ready && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("rstwait_accept", 32'(o_cmd_ready), 32'd1);
    @(negedge CLK);
    i_cmd_valid = 1'b0;
    check("rstwait_read", 32'(o_pq_read), 32'd1);
    check("rstwait_rsp", 32'(o_rsp_data), 32'(exp_top));
    q_pop();
    pins();
    repeat (5) @(negedge CLK);
    check("rstwait_busy", 32'(o_cmd_ready), 32'd0);
    RST = 1'b1;
    #1;
    check("rstmid_ready", 32'(o_cmd_ready), 32'd0);
    check("rstmid_read", 32'(o_pq_read), 32'd0);
    check("rstmid_wrt", 32'(o_pq_wrt), 32'd0);
    check("rstmid_pq_data", 32'(o_pq_data), 32'd0);
    check("rstmid_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rstmid_rsp_err", 32'(o_rsp_err), 32'd0);
    check("rstmid_rsp_data", 32'(o_rsp_data), 32'd0);
    @(negedge CLK);
    RST        = 1'b0;
    last_wdata = '0;
    @(negedge CLK);
    check("ready_after_rst2", 32'(o_cmd_ready), 32'd1);
    send(2'b01, 16'h1234, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
